// File: rtl/gfx256_pkg.sv
// gfx256_pkg: shared arbiter state encoding, client line-request record and one-hot helper.
package gfx256_pkg;
   typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
   typedef struct packed {
      logic        we;
      logic [31:5] adr;
      logic [31:0] sel;
      logic [255:0] dat;
   } gfx_line_req_t;
   function automatic logic [2:0] oh2idx(input logic [7:0] oh);
      oh2idx = '0;
      for (int k = 0; k < 8; k++) if (oh[k]) oh2idx = 3'(k);
   endfunction
endpackage

// File: rtl/gfx256_bus_arbiter_if.sv
// gfx256_bus_arbiter_if: client request/ack bundle plus the BIU side of the shared bus.
interface gfx256_bus_arbiter_if #(parameter int NREQ = 4);
   logic [NREQ-1:0]        req_i;
   logic [NREQ-1:0]        we_i;
   logic [NREQ-1:0][26:0]  adr_i;
   logic [NREQ-1:0][31:0]  sel_i;
   logic [NREQ-1:0][255:0] dat_i;
   logic [NREQ-1:0]        ack_o;
   logic [NREQ-1:0]        err_o;
   logic [255:0]           dat_o;
   logic [NREQ-1:0]        grant_o;
   logic                   busy_o;
   logic                   read_request_o;
   logic                   write_request_o;
   logic [26:0]            biu_addr_o;
   logic [31:0]            biu_sel_o;
   logic [255:0]           biu_dat_o;
   logic [255:0]           biu_dat_i;
   logic                   biu_ack_i;
   logic                   biu_err_i;
   modport master (
      input  req_i, we_i, adr_i, sel_i, dat_i, biu_dat_i, biu_ack_i, biu_err_i,
      output ack_o, err_o, dat_o, grant_o, busy_o, read_request_o, write_request_o,
             biu_addr_o, biu_sel_o, biu_dat_o
   );
   modport slave (
      output req_i, we_i, adr_i, sel_i, dat_i, biu_dat_i, biu_ack_i, biu_err_i,
      input  ack_o, err_o, dat_o, grant_o, busy_o, read_request_o, write_request_o,
             biu_addr_o, biu_sel_o, biu_dat_o
   );
endinterface

// File: rtl/gfx256_rr_pick.sv
// gfx256_rr_pick: combinational round-robin picker, first request at or above ptr, else lowest overall.
module gfx256_rr_pick #(parameter int N = 4) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic [N-1:0] gnt,
   output logic         vld
);
   logic [N-1:0] hi, pool;
   assign hi   = req & ~((N'(1) << ptr) - N'(1));
   assign pool = |hi ? hi : req;
   assign gnt  = pool & (~pool + N'(1));
   assign vld  = |req;
endmodule

// File: rtl/gfx256_bus_arbiter.sv
// gfx256_bus_arbiter: round-robin sharing of the gfx256 BIU, one transaction outstanding at a time.
// Optional WAIT watchdog enabled by defining GFX256_ARB_TIMEOUT_EN.
module gfx256_bus_arbiter
   import gfx256_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   gfx256_bus_arbiter_if.master bus
);
   arb_state_t      state;
   logic [2:0]      ptr, gidx;
   logic [NREQ-1:0] pick_gnt, grant, ack, err;
   logic            pick_vld, rd, wr, busy, expire, done;
   logic [26:0]     addr;
   logic [31:0]     sel;
   logic [255:0]    wdat, rdat;
   gfx_line_req_t   cand;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
      $error("gfx256_bus_arbiter: parameter out of range");
   end

   // a client is still holding req_i during its ack cycle, so keep it out of that arbitration
   gfx256_rr_pick #(.N(NREQ)) u_pick (
      .req (bus.req_i & ~ack),
      .ptr (ptr),
      .gnt (pick_gnt),
      .vld (pick_vld)
   );

   always_comb begin
      cand = '0;
      for (int k = 0; k < NREQ; k++)
         if (pick_gnt[k]) cand = '{we: bus.we_i[k], adr: bus.adr_i[k], sel: bus.sel_i[k], dat: bus.dat_i[k]};
   end

`ifdef GFX256_ARB_TIMEOUT_EN
   logic [15:0] cnt;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt <= '0;
      else cnt <= state == ARB_WAIT ? cnt + 16'd1 : '0;
   assign expire = state == ARB_WAIT && cnt == 16'(TIMEOUT_CYCLES - 1);
`else
   assign expire = 1'b0;
`endif

   assign gidx = oh2idx(8'(grant));
   assign done = bus.biu_ack_i || bus.biu_err_i || expire;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= ARB_IDLE;
         ptr   <= '0;
         grant <= '0;
         ack   <= '0;
         err   <= '0;
         rd    <= 1'b0;
         wr    <= 1'b0;
         busy  <= 1'b0;
         addr  <= '0;
         sel   <= '0;
         wdat  <= '0;
         rdat  <= '0;
      end else begin
         ack <= '0;
         err <= '0;
         rd  <= 1'b0;
         wr  <= 1'b0;
         if (state == ARB_IDLE && pick_vld) begin
            state <= ARB_ISSUE;
            grant <= pick_gnt;
            addr  <= cand.adr;
            sel   <= cand.sel;
            wdat  <= cand.dat;
            rd    <= ~cand.we;
            wr    <= cand.we;
            busy  <= 1'b1;
         end else if (state == ARB_ISSUE) begin
            state <= ARB_WAIT;
         end else if (state == ARB_WAIT && done) begin
            state <= ARB_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ack   <= grant;
            err   <= bus.biu_err_i || !bus.biu_ack_i ? grant : '0;
            rdat  <= bus.biu_ack_i ? bus.biu_dat_i : bus.biu_err_i ? rdat : '0;
            ptr   <= gidx == 3'(NREQ - 1) ? 3'd0 : gidx + 3'd1;
         end
      end
   end

   assign bus.ack_o           = ack;
   assign bus.err_o           = err;
   assign bus.dat_o           = rdat;
   assign bus.grant_o         = grant;
   assign bus.busy_o          = busy;
   assign bus.read_request_o  = rd;
   assign bus.write_request_o = wr;
   assign bus.biu_addr_o      = addr;
   assign bus.biu_sel_o       = sel;
   assign bus.biu_dat_o       = wdat;
endmodule
